// File: rtl/button_reader.sv
// button_reader: four independent debounced push-buttons with press,
// release and long-press strobes plus a shared running press counter.
// Each raw input is synchronized, then qualified by a per-button FSM that
// only accepts a level change after it has been stable for DEBOUNCE_CYCLES.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] long_pulse,
    output logic [7:0] press_count
);

    // Hold counter saturates at LONG_CYCLES itself, so it needs room for that value.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [3:0]        sync_meta;
    logic [3:0]        sync;

    state_t            state_q    [4];
    state_t            state_d    [4];
    logic [DB_W-1:0]   db_cnt_q   [4];
    logic [DB_W-1:0]   db_cnt_d   [4];
    logic [HOLD_W-1:0] hold_cnt_q [4];
    logic [HOLD_W-1:0] hold_cnt_d [4];
    logic [3:0]        long_fired_q;
    logic [3:0]        long_fired_d;

    logic [3:0]        level_d;
    logic [3:0]        press_d;
    logic [3:0]        release_d;
    logic [3:0]        long_d;
    logic [2:0]        press_inc;

    // Two-flop synchronizer; only the second stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make both stages sample the old values on the same edge.
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // Per-button next-state, counter and strobe logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        level_d      = btn_level;
        press_d      = '0;
        release_d    = '0;
        long_d       = '0;
        long_fired_d = long_fired_q;
        for (int b = 0; b < 4; b++) begin
            state_d[b]    = state_q[b];
            db_cnt_d[b]   = db_cnt_q[b];
            hold_cnt_d[b] = hold_cnt_q[b];

            // The hold timer runs while pressed, including a pending release.
            if (state_q[b] == HELD || state_q[b] == RELEASE_WAIT) begin
                if (hold_cnt_q[b] != HOLD_MAX)
                    hold_cnt_d[b] = hold_cnt_q[b] + HOLD_ONE;
                if (hold_cnt_q[b] == HOLD_LAST && !long_fired_q[b]) begin
                    long_d[b]       = 1'b1;
                    long_fired_d[b] = 1'b1;
                end
            end

            case (state_q[b])
                IDLE: begin
                    if (sync[b]) begin
                        state_d[b]  = PRESS_WAIT;
                        db_cnt_d[b] = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync[b]) begin
                        state_d[b] = IDLE;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        state_d[b]      = HELD;
                        press_d[b]      = 1'b1;
                        level_d[b]      = 1'b1;
                        hold_cnt_d[b]   = '0;
                        long_fired_d[b] = 1'b0;
                    end else begin
                        db_cnt_d[b] = db_cnt_q[b] + DB_ONE;
                    end
                end
                HELD: begin
                    if (!sync[b]) begin
                        state_d[b]  = RELEASE_WAIT;
                        db_cnt_d[b] = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync[b]) begin
                        state_d[b] = HELD;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        state_d[b]   = IDLE;
                        release_d[b] = 1'b1;
                        level_d[b]   = 1'b0;
                    end else begin
                        db_cnt_d[b] = db_cnt_q[b] + DB_ONE;
                    end
                end
                default: state_d[b] = IDLE;
            endcase
        end
        press_inc = 3'(press_d[0]) + 3'(press_d[1]) + 3'(press_d[2]) + 3'(press_d[3]);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                state_q[b]    <= IDLE;
                db_cnt_q[b]   <= '0;
                hold_cnt_q[b] <= '0;
            end
            long_fired_q  <= '0;
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            press_count   <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                state_q[b]    <= state_d[b];
                db_cnt_q[b]   <= db_cnt_d[b];
                hold_cnt_q[b] <= hold_cnt_d[b];
            end
            long_fired_q  <= long_fired_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            press_count   <= press_count + {5'd0, press_inc};
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: scenario tasks plus a run-length reference model of the
// debounce behaviour (a level flips after DB+1 consecutive differing samples
// of the two-cycle-delayed raw input; a long press fires LONG edges after
// acceptance while the level is still high).
module tb_button_reader;

    localparam int DB   = 4;
    localparam int LONG = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    button_reader #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0] m_d1, m_d2;            // raw input as sampled one and two edges ago
    logic [3:0] m_level, m_press, m_release, m_long;
    logic [7:0] m_count;
    int         m_run [4];             // consecutive samples differing from the level
    int         m_age [4];             // edges since the press was accepted
    logic [3:0] n_level, n_press, n_release, n_long;
    int         n_run [4];
    int         n_age [4];

    // Model next values from the run-length rule.
    always_comb begin
        n_level   = m_level;
        n_press   = '0;
        n_release = '0;
        n_long    = '0;
        for (int b = 0; b < 4; b++) begin
            n_age[b] = m_age[b];
            if (m_level[b]) begin
                if (m_age[b] <= LONG) n_age[b] = m_age[b] + 1;
                if (m_age[b] + 1 == LONG) n_long[b] = 1'b1;
            end
            n_run[b] = (m_d2[b] != m_level[b]) ? m_run[b] + 1 : 0;
            if (n_run[b] == DB + 1) begin
                n_run[b]   = 0;
                n_level[b] = ~m_level[b];
                if (m_level[b]) begin
                    n_release[b] = 1'b1;
                end else begin
                    n_press[b] = 1'b1;
                    n_age[b]   = 0;
                end
            end
        end
    end

    // Model registers, cleared asynchronously like the design.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 <= '0; m_d2 <= '0; m_level <= '0; m_press <= '0;
            m_release <= '0; m_long <= '0; m_count <= '0;
            for (int b = 0; b < 4; b++) begin
                m_run[b] <= 0;
                m_age[b] <= 0;
            end
        end else begin
            m_d1 <= btn_raw;
            m_d2 <= m_d1;
            m_level <= n_level;
            m_press <= n_press;
            m_release <= n_release;
            m_long <= n_long;
            m_count <= m_count + 8'($countones(n_press));
            m_run <= n_run;
            m_age <= n_age;
        end
    end

    logic [23:0] dut_vec, mdl_vec;
    assign dut_vec = {btn_level, press_pulse, release_pulse, long_pulse, press_count};
    assign mdl_vec = {m_level, m_press, m_release, m_long, m_count};

    task automatic test_reset();
        rst     = 1'b1;
        btn_raw = 4'hf;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 24'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected 000000", k, dut_vec);
            end
        end
        btn_raw = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] base;
        base = m_count;
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (press_pulse[0] !== (k == 6)) begin
                errors++;
                $display("FAIL clean_press_pulse edge %0d: got %b expected %b", k, press_pulse[0], k == 6);
            end
            if (k >= 6) begin
                checks++;
                if (btn_level[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_press_level edge %0d: got %b expected 1", k, btn_level[0]);
                end
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL clean_press_model edge %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (press_count !== base + 8'd1) begin
            errors++;
            $display("FAIL clean_press_count: got %0d expected %0d", press_count, base + 8'd1);
        end
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL clean_release_model cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] base;
        base = m_count;
        for (int k = 0; k < 16; k++) begin
            btn_raw[1] = (k < 4) && (k % 2 == 0);
            @(negedge clk);
            checks++;
            if ({press_pulse[1], release_pulse[1], long_pulse[1], btn_level[1]} !== 4'b0000) begin
                errors++;
                $display("FAIL bounce_quiet edge %0d: got p%b r%b l%b lvl%b expected all 0", k,
                         press_pulse[1], release_pulse[1], long_pulse[1], btn_level[1]);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL bounce_model edge %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (press_count !== base) begin
            errors++;
            $display("FAIL bounce_count: got %0d expected %0d", press_count, base);
        end
    endtask

    task automatic test_long_press();
        int n_p = 0, n_l = 0, n_r = 0;
        int k_p = -1, k_l = -1, k_r = -1;
        for (int k = 0; k < 46; k++) begin
            btn_raw[2] = (k < 30);
            @(negedge clk);
            if (press_pulse[2])   begin n_p++; k_p = k; end
            if (long_pulse[2])    begin n_l++; k_l = k; end
            if (release_pulse[2]) begin n_r++; k_r = k; end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL long_model edge %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (n_p != 1 || k_p != 6) begin
            errors++;
            $display("FAIL long_press_pulse: got %0d pulses at edge %0d expected 1 at 6", n_p, k_p);
        end
        checks++;
        if (n_l != 1 || k_l - k_p != LONG) begin
            errors++;
            $display("FAIL long_pulse: got %0d pulses, %0d after press expected 1, %0d", n_l, k_l - k_p, LONG);
        end
        checks++;
        if (n_r != 1 || k_r != 36) begin
            errors++;
            $display("FAIL long_release: got %0d pulses at edge %0d expected 1 at 36", n_r, k_r);
        end
    endtask

    task automatic test_release_glitch();
        int n_p = 0, n_r = 0, k_r = -1;
        for (int k = 0; k < 40; k++) begin
            btn_raw[0] = (k < 30) && !(k == 12 || k == 13);
            @(negedge clk);
            if (press_pulse[0])   n_p++;
            if (release_pulse[0]) begin n_r++; k_r = k; end
            if (k >= 6 && k < 36) begin
                checks++;
                if (btn_level[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_level edge %0d: got %b expected 1", k, btn_level[0]);
                end
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL glitch_model edge %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (n_p != 1) begin
            errors++;
            $display("FAIL glitch_press_count: got %0d pulses expected 1", n_p);
        end
        checks++;
        if (n_r != 1 || k_r != 36) begin
            errors++;
            $display("FAIL glitch_release: got %0d pulses at edge %0d expected 1 at 36", n_r, k_r);
        end
    endtask

    task automatic test_random();
        int unsigned dur [4];
        for (int b = 0; b < 4; b++) dur[b] = $urandom_range(24, 1);
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 4; b++) begin
                dur[b]--;
                if (dur[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    dur[b]     = $urandom_range(24, 1);
                end
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL random_settle cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] need;
        logic [3:0] pat;
        for (int it = 0; it < 300 && m_count != 8'd254; it++) begin
            need = 8'd254 - m_count;
            pat  = (need >= 8'd4) ? 4'hf : 4'h1;
            for (int k = 0; k < 16; k++) begin
                btn_raw = (k < 8) ? pat : 4'h0;
                @(negedge clk);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++;
                    $display("FAIL wrap_preload_model iter %0d cycle %0d: got %h expected %h", it, k, dut_vec, mdl_vec);
                end
            end
        end
        checks++;
        if (press_count !== 8'd254) begin
            errors++;
            $display("FAIL wrap_preload: got %0d expected 254", press_count);
        end
        for (int k = 0; k < 10; k++) begin
            btn_raw = 4'hf;
            @(negedge clk);
            checks++;
            if (press_pulse !== ((k == 6) ? 4'hf : 4'h0)) begin
                errors++;
                $display("FAIL wrap_pulse edge %0d: got %b expected %b", k, press_pulse, (k == 6) ? 4'hf : 4'h0);
            end
        end
        checks++;
        if (press_count !== 8'd2) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 2", press_count);
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL wrap_release_model cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_raw = 4'b1000;
        for (int k = 0; k < 10; k++) @(negedge clk);
        checks++;
        if (btn_level[3] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_held: got %b expected 1", btn_level[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 000000", dut_vec);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h expected 000000", dut_vec);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (press_pulse[3] !== (k == 6) || release_pulse !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid_repress edge %0d: got p%b r%b expected p%b r0000", k,
                         press_pulse[3], release_pulse, k == 6);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL reset_mid_model edge %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d expected 1", press_count);
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500_000, the number of clk cycles a synchronized input must be stable before a level change is accepted (10 ms at 50 MHz); legal range >= 2.
REQ-002 The module SHALL have parameter LONG_CYCLES, default 50_000_000, the number of clk cycles in the held state before a long press is flagged (1 s at 50 MHz); it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  4  raw, asynchronous, bouncing push-button levels; 1 means pressed.
REQ-006 btn_level  output  4  debounced button level per button.
REQ-007 press_pulse  output  4  one-cycle strobe per button on an accepted press.
REQ-008 release_pulse  output  4  one-cycle strobe per button on an accepted release.
REQ-009 long_pulse  output  4  one-cycle strobe per button when a hold reaches LONG_CYCLES.
REQ-010 press_count  output  8  running count of accepted presses on any button.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second-flop output ("sync") feeds the logic.
REQ-012 Each button SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD, and RELEASE_WAIT, plus its own debounce counter and hold counter, each sized with $clog2 of its limit.
REQ-013 IDLE: if sync=1, go to PRESS_WAIT and clear the debounce counter.
REQ-014 PRESS_WAIT: if sync=0, return to IDLE with no output (bounce rejected); otherwise increment; if the counter is DEBOUNCE_CYCLES-1 and sync=1, go to HELD, register press_pulse=1 and btn_level=1, and clear the hold counter.
REQ-015 Latency: with btn_raw stable high from sampling edge 0, press_pulse SHALL be high for exactly the one cycle after edge DEBOUNCE_CYCLES+2. Release latency is identical.
REQ-016 HELD: increment the hold counter, saturating at LONG_CYCLES. long_pulse SHALL assert for one cycle when the count reaches LONG_CYCLES-1, and at most once per press. If sync=0, go to RELEASE_WAIT and clear the debounce counter.
REQ-017 RELEASE_WAIT: if sync=1, return to HELD with no output, keeping the hold counter and the long-fired flag. Otherwise increment; if the counter is DEBOUNCE_CYCLES-1, go to IDLE, register release_pulse=1 and btn_level=0.
REQ-018 The hold counter SHALL keep counting in RELEASE_WAIT, so long_pulse may fire there.
REQ-019 press_count SHALL increment by the number of press_pulse bits set in that cycle (0-4), modulo 256; 255+1 wraps to 0.
REQ-020 All outputs SHALL be registered; no output SHALL combinationally depend on btn_raw.
REQ-021 Buttons SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses on each bit.

Reset
REQ-022 While rst=1, all of the following SHALL hold asynchronously: synchronizer flops 0, all FSMs IDLE, all counters 0, long-fired flags 0, and all outputs 0.
REQ-023 Reset asserted mid-press (any state) SHALL abort that press with no release_pulse.
REQ-024 After rst deasserts with btn_raw held high, a normal press SHALL be detected after the REQ-015 latency.

Verification (bench runs DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-025 Clean press: btn_raw[0] 0->1 at edge 0, held 10 cycles -> press_pulse[0]=1 only in the cycle after edge 6, btn_level[0]=1 from then on, press_count=1.
REQ-026 Bounce rejection: btn_raw[1] toggles 1,0,1,0 each cycle, then stays 0 -> no pulses, btn_level[1]=0, press_count unchanged.
REQ-027 Long press: btn_raw[2] held high 30 cycles, then released -> press_pulse once, long_pulse[2] once (16 cycles after press_pulse), and release_pulse[2] once 6 cycles after btn_raw falls.
REQ-028 Release glitch: held button drops to 0 for 2 cycles, then returns to 1 -> no release_pulse, btn_level stays 1, and no second press_pulse.
REQ-029 Simultaneous press and wrap: all 4 bits rise together with press_count=254 -> press_pulse=4'b1111 in one cycle, press_count=2.
REQ-030 Reset mid-operation: rst pulsed while button 3 is in HELD -> all outputs 0 immediately, no release_pulse; with btn_raw[3] still high, press_pulse[3] follows 6 edges after rst deasserts.
